// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
//   arb_state_t : arbiter FSM state encoding
//   GRANT_*     : one-hot grant vector values
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Saturating wait-state counter guarding an owned Wishbone strobe.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the count (not owned, strobe low, or slave answered)
//   run        : strobe outstanding without ack/err this cycle
//   expired    : this edge brings the count to TIMEOUT; owner must be aborted
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int              CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0]   ONE   = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && (cnt != LIMIT)) begin
      cnt <= cnt + ONE;
    end
  end

  // Flag on the edge that would make the count equal TIMEOUT, so the abort
  // cycle is the (TIMEOUT+1)-th cycle of an unanswered strobe.
  assign expired = run && (cnt >= (LIMIT - ONE));

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter with a slave-timeout watchdog.
// Master 0 is the UART bridge, master 1 a second bus master. The owner keeps
// the bus for its whole cyc tenure; at least one IDLE cycle separates owners.
// Ports:
//   wb_clk, wb_rst_n        : clock, asynchronous active-low reset
//   mN_adr/dat_w/sel/we/cyc/stb : master N request (N = 0, 1)
//   mN_dat_r/ack/err        : response to master N
//   s_adr/dat_w/sel/we/cyc/stb : slave-side request
//   s_dat_r/ack/err         : slave response
//   grant                   : one-hot current owner, 00 = none
//   timeout                 : one-cycle pulse on watchdog abort
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_w,
  input  logic [3:0]    m0_sel,
  input  logic          m0_we,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  output logic [DW-1:0] m0_dat_r,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_w,
  input  logic [3:0]    m1_sel,
  input  logic          m1_we,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  output logic [DW-1:0] m1_dat_r,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_w,
  output logic [3:0]    s_sel,
  output logic          s_we,
  output logic          s_cyc,
  output logic          s_stb,
  input  logic [DW-1:0] s_dat_r,
  input  logic          s_ack,
  input  logic          s_err,
  output logic [1:0]    grant,
  output logic          timeout
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       owned;
  logic       wd_clr;
  logic       wd_run;
  logic       wd_expired;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // The watchdog only counts while an owned strobe waits for an answer.
  assign owned  = (state_q == OWN0) || (state_q == OWN1);
  assign wd_clr = !owned || !s_stb || s_ack || s_err;
  assign wd_run = !wd_clr;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (wb_clk),
    .rst_n   (wb_rst_n),
    .clr     (wd_clr),
    .run     (wd_run),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // On a tie the master that was not served last wins.
        if (m0_cyc && m1_cyc) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (m0_cyc) begin
          state_d = OWN0;
        end else if (m1_cyc) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (wd_expired) begin
          state_d = ABORT;
          last_d  = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (wd_expired) begin
          state_d = ABORT;
          last_d  = 1'b1;
        end
      end
      ABORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    s_adr    = '0;
    s_dat_w  = '0;
    s_sel    = '0;
    s_we     = 1'b0;
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    m0_dat_r = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m1_dat_r = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    grant    = GRANT_NONE;
    timeout  = 1'b0;
    case (state_q)
      OWN0: begin
        grant    = GRANT_M0;
        s_adr    = m0_adr;
        s_dat_w  = m0_dat_w;
        s_sel    = m0_sel;
        s_we     = m0_we;
        s_cyc    = m0_cyc;
        // A strobe is never forwarded once the owner has dropped cyc.
        s_stb    = m0_cyc && m0_stb;
        m0_dat_r = s_dat_r;
        m0_ack   = s_ack;
        m0_err   = s_err;
      end
      OWN1: begin
        grant    = GRANT_M1;
        s_adr    = m1_adr;
        s_dat_w  = m1_dat_w;
        s_sel    = m1_sel;
        s_we     = m1_we;
        s_cyc    = m1_cyc;
        s_stb    = m1_cyc && m1_stb;
        m1_dat_r = s_dat_r;
        m1_ack   = s_ack;
        m1_err   = s_err;
      end
      ABORT: begin
        // last already names the aborted owner.
        timeout = 1'b1;
        if (last_q) begin
          m1_err = 1'b1;
        end else begin
          m0_err = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
module tb_wb_master_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          wb_clk   = 1'b0;
  logic          wb_rst_n = 1'b0;
  logic [AW-1:0] m0_adr   = '0;
  logic [DW-1:0] m0_dat_w = '0;
  logic [3:0]    m0_sel   = '0;
  logic          m0_we    = 1'b0;
  logic          m0_cyc   = 1'b0;
  logic          m0_stb   = 1'b0;
  logic [AW-1:0] m1_adr   = '0;
  logic [DW-1:0] m1_dat_w = '0;
  logic [3:0]    m1_sel   = '0;
  logic          m1_we    = 1'b0;
  logic          m1_cyc   = 1'b0;
  logic          m1_stb   = 1'b0;
  logic [DW-1:0] s_dat_r  = '0;
  logic          s_ack    = 1'b0;
  logic          s_err    = 1'b0;

  logic [DW-1:0] m0_dat_r, m1_dat_r, s_dat_w;
  logic [AW-1:0] s_adr;
  logic [3:0]    s_sel;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_we, s_cyc, s_stb, timeout;
  logic [1:0]    grant;

  wb_master_arbiter #(
    .DW      (DW),
    .AW      (AW),
    .TIMEOUT (TO)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .m0_adr   (m0_adr),
    .m0_dat_w (m0_dat_w),
    .m0_sel   (m0_sel),
    .m0_we    (m0_we),
    .m0_cyc   (m0_cyc),
    .m0_stb   (m0_stb),
    .m0_dat_r (m0_dat_r),
    .m0_ack   (m0_ack),
    .m0_err   (m0_err),
    .m1_adr   (m1_adr),
    .m1_dat_w (m1_dat_w),
    .m1_sel   (m1_sel),
    .m1_we    (m1_we),
    .m1_cyc   (m1_cyc),
    .m1_stb   (m1_stb),
    .m1_dat_r (m1_dat_r),
    .m1_ack   (m1_ack),
    .m1_err   (m1_err),
    .s_adr    (s_adr),
    .s_dat_w  (s_dat_w),
    .s_sel    (s_sel),
    .s_we     (s_we),
    .s_cyc    (s_cyc),
    .s_stb    (s_stb),
    .s_dat_r  (s_dat_r),
    .s_ack    (s_ack),
    .s_err    (s_err),
    .grant    (grant),
    .timeout  (timeout)
  );

  always #5 wb_clk = ~wb_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, whether this cycle is an abort, who
  // was served last, and how many edges the current strobe has waited.
  int own    = -1;
  bit ab     = 1'b0;
  int ab_who = 0;
  int lst    = 1;
  int wt     = 0;

  function automatic logic cyc_of(input int n);
    return (n == 0) ? m0_cyc : m1_cyc;
  endfunction

  function automatic logic stb_of(input int n);
    return (n == 0) ? m0_stb : m1_stb;
  endfunction

  always @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      own <= -1;
      ab  <= 1'b0;
      lst <= 1;
      wt  <= 0;
    end else if (ab) begin
      ab  <= 1'b0;
      own <= -1;
    end else if (own < 0) begin
      wt <= 0;
      if (m0_cyc && m1_cyc) own <= 1 - lst;
      else if (m0_cyc)      own <= 0;
      else if (m1_cyc)      own <= 1;
    end else if (!cyc_of(own)) begin
      own <= -1;
      lst <= own;
      wt  <= 0;
    end else if (stb_of(own) && !s_ack && !s_err) begin
      if (wt + 1 >= TO) begin
        ab     <= 1'b1;
        ab_who <= own;
        lst    <= own;
        own    <= -1;
        wt     <= 0;
      end else begin
        wt <= wt + 1;
      end
    end else begin
      wt <= 0;
    end
  end

  bit chk_on = 1'b0;

  always @(negedge wb_clk) begin
    if (chk_on) begin
      chk("grant", grant, (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00);
      chk("timeout", timeout, ab);
      chk("s_cyc", s_cyc, (own == 0) ? m0_cyc : (own == 1) ? m1_cyc : 1'b0);
      chk("s_stb", s_stb, (own == 0) ? (m0_cyc & m0_stb) : (own == 1) ? (m1_cyc & m1_stb) : 1'b0);
      chk("s_we", s_we, (own == 0) ? m0_we : (own == 1) ? m1_we : 1'b0);
      chk("s_adr", s_adr, (own == 0) ? m0_adr : (own == 1) ? m1_adr : '0);
      chk("s_dat_w", s_dat_w, (own == 0) ? m0_dat_w : (own == 1) ? m1_dat_w : '0);
      chk("s_sel", s_sel, (own == 0) ? m0_sel : (own == 1) ? m1_sel : 4'h0);
      chk("m0_ack", m0_ack, (own == 0) && s_ack);
      chk("m1_ack", m1_ack, (own == 1) && s_ack);
      chk("m0_err", m0_err, ((own == 0) && s_err) || (ab && ab_who == 0));
      chk("m1_err", m1_err, ((own == 1) && s_err) || (ab && ab_who == 1));
      if (own == 0) chk("m0_dat_r", m0_dat_r, s_dat_r);
      if (own == 1) chk("m1_dat_r", m1_dat_r, s_dat_r);
    end
  end

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  int  acks;
  int  gcnt;
  bit  seen;

  initial begin
    chk_on = 1'b1;
    step();
    step();
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_m0_dat_r", m0_dat_r, 32'h0);
    chk("rst_m1_dat_r", m1_dat_r, 32'h0);
    wb_rst_n = 1'b1;
    step();

    // Single read with three wait states.
    m0_adr = 32'h10; m0_we = 1'b0; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
    step(); #1;
    chk("rd_grant", grant, 2'b01);
    chk("rd_s_adr", s_adr, 32'h10);
    step(); step(); step();
    s_dat_r = 32'hDEADBEEF; s_ack = 1'b1; #1;
    chk("rd_m0_ack", m0_ack, 1'b1);
    chk("rd_m0_dat_r", m0_dat_r, 32'hDEADBEEF);
    chk("rd_m1_ack", m1_ack, 1'b0);
    step();
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0; s_dat_r = '0; #1;
    chk("rd_release_s_cyc", s_cyc, 1'b0);
    step(); #1;
    chk("rd_idle", grant, 2'b00);

    // Tie after reset: m0, then m1 after one idle cycle, then m0 again.
    wb_rst_n = 1'b0; step(); wb_rst_n = 1'b1; step();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    step(); #1;
    chk("tie1_m0", grant, 2'b01);
    m0_cyc = 1'b0;
    step(); #1;
    chk("tie_gap", grant, 2'b00);
    step(); #1;
    chk("tie2_m1", grant, 2'b10);
    m1_cyc = 1'b0;
    step();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    step(); #1;
    chk("tie3_m0", grant, 2'b01);
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    step(); step();

    // Burst: m1 holds cyc for four acked writes while m0 waits.
    m1_adr = 32'h100; m1_we = 1'b1; m1_sel = 4'hF; m1_cyc = 1'b1; m1_stb = 1'b1;
    step(); #1;
    chk("burst_grant_m1", grant, 2'b10);
    m0_adr = 32'h20; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      m1_adr = 32'h100 + 32'(4 * i);
      m1_dat_w = 32'hA000 + 32'(i);
      s_ack = 1'b1; #1;
      if (m1_ack) acks++;
      chk("burst_m0_ack", m0_ack, 1'b0);
      chk("burst_hold", grant, 2'b10);
      step();
    end
    chk("burst_acks", acks, 4);
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    step(); #1;
    chk("burst_gap", grant, 2'b00);
    step(); #1;
    chk("burst_m0_granted", grant, 2'b01);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step(); step();

    // Watchdog on an unresponsive address.
    m0_adr = 32'hBAD0; m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    gcnt = 0; seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      #1;
      if (timeout) begin
        seen = 1'b1;
        chk("wd_m0_err", m0_err, 1'b1);
        chk("wd_s_cyc", s_cyc, 1'b0);
        chk("wd_s_stb", s_stb, 1'b0);
        chk("wd_grant", grant, 2'b00);
      end else begin
        if (grant == 2'b01) gcnt++;
        step();
      end
    end
    chk("wd_seen", seen, 1'b1);
    chk("wd_owned_cycles", gcnt, 8);
    step(); #1;
    chk("wd_pulse_once", timeout, 1'b0);
    chk("wd_idle", grant, 2'b00);
    step(); #1;
    chk("wd_rearbitrated", grant, 2'b01);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step(); step();

    // Error passthrough clears the watchdog; ack and err together pass through.
    m1_adr = 32'h300; m1_we = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step(); step(); step(); step();
    s_err = 1'b1; #1;
    chk("err_m1_err", m1_err, 1'b1);
    chk("err_timeout", timeout, 1'b0);
    chk("err_m0_err", m0_err, 1'b0);
    step();
    s_err = 1'b0;
    for (int i = 0; i < 6; i++) step();
    #1;
    chk("err_cleared_timeout", timeout, 1'b0);
    chk("err_cleared_grant", grant, 2'b10);
    s_ack = 1'b1; s_err = 1'b1; #1;
    chk("both_m1_ack", m1_ack, 1'b1);
    chk("both_m1_err", m1_err, 1'b1);
    step();
    s_ack = 1'b0; s_err = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step(); step();

    // Reset during an m0 wait state.
    m0_adr = 32'h40; m0_cyc = 1'b1; m0_stb = 1'b1;
    step(); step(); #1;
    chk("rstx_pre_grant", grant, 2'b01);
    chk("rstx_pre_s_cyc", s_cyc, 1'b1);
    wb_rst_n = 1'b0; s_ack = 1'b1; s_err = 1'b1; #1;
    chk("rstx_s_cyc", s_cyc, 1'b0);
    chk("rstx_s_stb", s_stb, 1'b0);
    chk("rstx_grant", grant, 2'b00);
    chk("rstx_m0_ack", m0_ack, 1'b0);
    chk("rstx_m0_err", m0_err, 1'b0);
    step();
    s_ack = 1'b0; s_err = 1'b0; wb_rst_n = 1'b1; m1_cyc = 1'b1;
    step(); #1;
    chk("rstx_tie_m0", grant, 2'b01);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0;
    step(); step();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
